// File: rtl/allbit_run_monitor.sv
// Run tracker behind the 32-bit all-zero/all-one detector: counts zero runs,
// one runs and mixed words, raises sticky alarms and can stall upstream.
module allbit_run_monitor #(
    parameter int RUN_W          = 8,
    parameter int ZERO_LIMIT     = 4,
    parameter int ONE_LIMIT      = 4,
    parameter bit STALL_ON_ALARM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_zero,
    input  logic             in_one,
    input  logic             alarm_ack,
    input  logic             clr,
    output logic [1:0]       state,
    output logic [RUN_W-1:0] zero_run,
    output logic [RUN_W-1:0] one_run,
    output logic [RUN_W-1:0] mixed_cnt,
    output logic             zero_alarm,
    output logic             one_alarm,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ZRUN  = 2'b01,
        S_ORUN  = 2'b10,
        S_MIXED = 2'b11
    } state_t;

    localparam logic [RUN_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] CNT_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] Z_LIM   = RUN_W'(ZERO_LIMIT);
    localparam logic [RUN_W-1:0] O_LIM   = RUN_W'(ONE_LIMIT);

    state_t           r_state;
    logic [RUN_W-1:0] r_zero_run;
    logic [RUN_W-1:0] r_one_run;
    logic [RUN_W-1:0] r_mixed_cnt;
    logic             r_zero_alarm;
    logic             r_one_alarm;
    logic             r_err;
    logic             r_live;

    state_t           w_state_nx;
    logic [RUN_W-1:0] w_zero_nx;
    logic [RUN_W-1:0] w_one_nx;
    logic [RUN_W-1:0] w_mixed_nx;
    logic             w_zero_set;
    logic             w_one_set;
    logic             w_err_set;
    logic             w_accept;
    logic             w_is_z;
    logic             w_is_o;

    // Handshake: a word is consumed on a rising edge where in_valid and
    // in_ready are both high; in_ready depends only on registered state.
    assign in_ready = r_live & ~(STALL_ON_ALARM & (r_zero_alarm | r_one_alarm));
    assign w_accept = in_valid & in_ready;
    assign w_is_z   = in_zero & ~in_one;
    assign w_is_o   = in_one & ~in_zero;

    always_comb begin
        w_state_nx = r_state;
        w_zero_nx  = r_zero_run;
        w_one_nx   = r_one_run;
        w_mixed_nx = r_mixed_cnt;
        w_zero_set = 1'b0;
        w_one_set  = 1'b0;
        w_err_set  = 1'b0;
        if (w_accept) begin
            if (w_is_z) begin
                w_state_nx = S_ZRUN;
                w_one_nx   = '0;
                if (r_state != S_ZRUN)
                    w_zero_nx = CNT_ONE;
                else if (r_zero_run != CNT_MAX)
                    w_zero_nx = r_zero_run + CNT_ONE;
                // A saturated run holding at the limit must not re-fire.
                w_zero_set = (w_zero_nx == Z_LIM) && (w_zero_nx != r_zero_run);
            end else if (w_is_o) begin
                w_state_nx = S_ORUN;
                w_zero_nx  = '0;
                if (r_state != S_ORUN)
                    w_one_nx = CNT_ONE;
                else if (r_one_run != CNT_MAX)
                    w_one_nx = r_one_run + CNT_ONE;
                w_one_set = (w_one_nx == O_LIM) && (w_one_nx != r_one_run);
            end else begin
                w_state_nx = S_MIXED;
                w_zero_nx  = '0;
                w_one_nx   = '0;
                if (r_mixed_cnt != CNT_MAX)
                    w_mixed_nx = r_mixed_cnt + CNT_ONE;
                w_err_set = in_zero & in_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_zero_run   <= '0;
            r_one_run    <= '0;
            r_mixed_cnt  <= '0;
            r_zero_alarm <= 1'b0;
            r_one_alarm  <= 1'b0;
            r_err        <= 1'b0;
            r_live       <= 1'b0;
        end else if (clr) begin
            r_state      <= S_IDLE;
            r_zero_run   <= '0;
            r_one_run    <= '0;
            r_mixed_cnt  <= '0;
            r_zero_alarm <= 1'b0;
            r_one_alarm  <= 1'b0;
            r_err        <= 1'b0;
            r_live       <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_zero_run   <= w_zero_nx;
            r_one_run    <= w_one_nx;
            r_mixed_cnt  <= w_mixed_nx;
            // Set beats a simultaneous acknowledge.
            r_zero_alarm <= w_zero_set | (r_zero_alarm & ~alarm_ack);
            r_one_alarm  <= w_one_set | (r_one_alarm & ~alarm_ack);
            r_err        <= w_err_set | (r_err & ~alarm_ack);
            r_live       <= 1'b1;
        end
    end

    assign state      = r_state;
    assign zero_run   = r_zero_run;
    assign one_run    = r_one_run;
    assign mixed_cnt  = r_mixed_cnt;
    assign zero_alarm = r_zero_alarm;
    assign one_alarm  = r_one_alarm;
    assign err        = r_err;

endmodule

// File: doc/allbit_run_monitor.md
Name: allbit_run_monitor

Overview:
- Downstream stage of the 32-bit all-zero/all-one detector. Consumes one classification (zero flag, one flag) per accepted word over a valid/ready handshake.
- Tracks consecutive runs of all-zero and all-one words and counts mixed words.
- Raises sticky alarms when a run reaches a programmed limit. Can stall the upstream stage until software acknowledges the alarm.

Parameters:
- RUN_W, 8, width of the run and mixed counters (saturating).
- ZERO_LIMIT, 4, zero-run length that sets zero_alarm (1..2^RUN_W-1).
- ONE_LIMIT, 4, one-run length that sets one_alarm (1..2^RUN_W-1).
- STALL_ON_ALARM, 1, when 1, in_ready is held low while any alarm is set.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a classification is presented.
- in_ready  output  1  the block accepts the classification this cycle.
- in_zero  input  1  the word is all zeros.
- in_one  input  1  the word is all ones.
- alarm_ack  input  1  clears both alarms and err (one-cycle pulse).
- clr  input  1  synchronous clear of counters, state, alarms and err.
- state  output  2  00 IDLE, 01 ZRUN, 10 ORUN, 11 MIXED.
- zero_run  output  RUN_W  length of the current zero run.
- one_run  output  RUN_W  length of the current one run.
- mixed_cnt  output  RUN_W  total mixed words since reset or clr (saturating).
- zero_alarm  output  1  sticky; the zero run reached ZERO_LIMIT.
- one_alarm  output  1  sticky; the one run reached ONE_LIMIT.
- err  output  1  sticky; in_zero and in_one were both high on an accepted word.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. zero_run, one_run and mixed_cnt are 0. zero_alarm, one_alarm and err are 0. in_ready=1 one cycle after rst_n rises, and 0 while rst_n=0.
- Accept: accept = in_valid & in_ready, sampled on the rising edge. All outputs are registered and reflect an accepted word on the following cycle (latency 1).
- in_ready = ~(STALL_ON_ALARM & (zero_alarm | one_alarm)). It is combinational from registered alarms only, with no path from in_valid.
- Classification of an accepted word:
  - Z = in_zero & ~in_one.
  - O = in_one & ~in_zero.
  - Anything else is M.
  - in_zero & in_one also sets err; that word is treated as M.
- Transitions on accept:
  - Z from any state: go to ZRUN. zero_run = 1 if the previous state was not ZRUN, otherwise zero_run+1 (saturates at all-ones). one_run = 0.
  - O from any state: go to ORUN. Same rules with the roles of zero_run and one_run swapped.
  - M: go to MIXED. zero_run = 0, one_run = 0, mixed_cnt+1 (saturating).
  - No accept: state and counters hold.
- Alarms:
  - zero_alarm sets on the same edge that zero_run becomes == ZERO_LIMIT.
  - Once set, it stays set while the run continues or ends, until alarm_ack or clr.
  - one_alarm follows the same rule with ONE_LIMIT.
- alarm_ack and a new alarm-setting accept on the same edge: set wins (alarm remains 1).
- clr has priority over accept and alarm_ack on the same edge: everything returns to its reset values and the accepted word is discarded.
- Saturation: when a counter is at 2^RUN_W-1, further increments hold the value. The alarm is not re-triggered and state is unaffected.
- A stalled input (in_valid=1, in_ready=0) is not consumed. Upstream must hold its data, and the block counts it once after the stall releases.
- Reset mid-run: all counters and alarms clear immediately. No partial run survives.

Test Plan:
1. After reset, present Z for 3 cycles, then O for 2 cycles -> state ZRUN with zero_run 1,2,3; then ORUN with one_run 1,2 and zero_run=0; mixed_cnt=0; no alarm.
2. ZERO_LIMIT=4, STALL_ON_ALARM=1; present 5 consecutive Z with in_valid held -> zero_alarm=1 the cycle after the 4th accept; in_ready=0 and the 5th word stalls; pulse alarm_ack -> in_ready=1, 5th word accepted, zero_run=5, zero_alarm stays 0.
3. Present M,Z,M,M (as 0x12345678, 0, 0x12345678, 0x00000020 classified upstream) -> mixed_cnt=3, final state MIXED, zero_run=0.
4. Present in_zero=1 and in_one=1 together -> err=1, state MIXED, mixed_cnt+1; alarm_ack clears err.
5. RUN_W=3, ONE_LIMIT=7; present 10 O -> one_run saturates at 7, one_alarm set once, state ORUN.
6. Deassert rst_n mid-ORUN (one_run=3, one_alarm=1) asynchronously between edges -> all outputs 0 immediately. Assert clr in the same cycle as an accepted Z -> zero_run=0, state IDLE.
